game_sequencer: RTL

- Top-level game-flow controller for the Pac-Man datapath. It sequences the pacman and ghost movers and the color mapper through the phases attract, ready, play, dying, level-clear and game-over.
- Owns the lives, level and score counters.
- Gates sprite motion through `freeze` and repositions sprites through an `entity_reset` pulse.
- Runs on the 50 MHz system clock. Frame timing comes from the VGA vertical sync.

---
 rtl/game_pkg.sv | 24 ++
 rtl/game_sequencer_frame_tick_sync.sv | 28 ++
 rtl/game_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the Pac-Man game-flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DYING = 3'd3,
        ST_CLEAR = 3'd4,
        ST_OVER  = 3'd5
    } game_state_t;

    localparam int SCORE_MAX      = 16383;
    localparam int EXTRA_LIFE_PTS = 10000;
    localparam int LEVEL_MAX      = 15;

    // Saturating score add; the sum is formed one bit wider so it cannot wrap.
    function automatic logic [13:0] score_add(input logic [13:0] a, input int pts);
        logic [14:0] s;
        s = {1'b0, a} + 15'(pts);
        return (int'(s) > SCORE_MAX) ? 14'(SCORE_MAX) : s[13:0];
    endfunction

endpackage

// File: rtl/game_sequencer_frame_tick_sync.sv
// Brings VGA vertical sync into the Clk domain and emits one-cycle frame_tick per rising edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic frame_tick
);

    logic [1:0] r_sync;
    logic       r_prev;
    logic       r_tick;

    // Registered edge detect puts the tick three Clk edges after the VS edge.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], frame_clk};
            r_prev <= r_sync[1];
            r_tick <= r_sync[1] & ~r_prev;
        end
    end

    assign frame_tick = r_tick;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow FSM: phases, frame timer, lives/level/score counters, blink.
// Optional extra life at 10000 points: define GAME_SEQ_EXTRA_LIFE_EN.
module game_sequencer
    import game_pkg::*;
#(
    parameter int START_LIVES  = 3,
    parameter int READY_FRAMES = 120,
    parameter int DEATH_FRAMES = 90,
    parameter int CLEAR_FRAMES = 120,
    parameter int OVER_FRAMES  = 180,
    parameter int BLINK_FRAMES = 15,
    parameter int PELLET_PTS   = 10
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        start_btn,
    input  logic        collision,
    input  logic        pellet_eaten,
    input  logic        level_clear,
    output logic [2:0]  game_state,
    output logic        freeze,
    output logic        entity_reset,
    output logic [1:0]  lives,
    output logic [3:0]  level,
    output logic [13:0] score,
    output logic        blink
);

    game_state_t r_state, w_next;
    logic [7:0]  r_timer, w_load;
    logic [7:0]  r_blink_cnt;
    logic        r_blink;
    logic        r_er, w_er;
    logic [1:0]  r_lives, w_lives_nx;
    logic [3:0]  r_level, w_level_nx;
    logic [13:0] r_score, w_score_nx;
    logic        w_tick, w_expire, w_entry, w_start, w_blink_st;

    frame_tick_sync u_tick (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .frame_tick (w_tick)
    );

    assign w_expire   = w_tick && (r_timer == 8'd0);
    assign w_start    = (r_state == ST_IDLE) && start_btn;
    assign w_blink_st = (r_state == ST_READY) || (r_state == ST_OVER);

    always_ff @(posedge Clk) begin
        if (!Reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_er   = 1'b0;
        case (r_state)
            ST_IDLE:  if (start_btn) begin w_next = ST_READY; w_er = 1'b1; end
            ST_READY: if (w_expire) w_next = ST_PLAY;
            ST_PLAY: begin
                if (collision)        w_next = ST_DYING;
                else if (level_clear) w_next = ST_CLEAR;
            end
            ST_DYING: begin
                if (w_expire) begin
                    if (r_lives == 2'd0) w_next = ST_OVER;
                    else begin w_next = ST_READY; w_er = 1'b1; end
                end
            end
            ST_CLEAR: if (w_expire) begin w_next = ST_READY; w_er = 1'b1; end
            ST_OVER:  if (w_expire) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign w_entry = (w_next != r_state);

    always_comb begin
        w_load = 8'd0;
        case (w_next)
            ST_READY: w_load = 8'(READY_FRAMES);
            ST_DYING: w_load = 8'(DEATH_FRAMES);
            ST_CLEAR: w_load = 8'(CLEAR_FRAMES);
            ST_OVER:  w_load = 8'(OVER_FRAMES);
            default:  w_load = 8'd0;
        endcase
    end

    always_comb begin
        w_score_nx = r_score;
        if (w_start)                                    w_score_nx = 14'd0;
        else if ((r_state == ST_PLAY) && pellet_eaten)  w_score_nx = score_add(r_score, PELLET_PTS);
    end

    always_comb begin
        w_level_nx = r_level;
        if (w_start) w_level_nx = 4'd0;
        else if ((r_state == ST_CLEAR) && w_expire && (int'(r_level) < LEVEL_MAX))
            w_level_nx = r_level + 4'd1;
    end

`ifdef GAME_SEQ_EXTRA_LIFE_EN
    logic r_xl_given;
    logic w_cross;

    assign w_cross = (int'(r_score) < EXTRA_LIFE_PTS) && (int'(w_score_nx) >= EXTRA_LIFE_PTS);

    always_ff @(posedge Clk) begin
        if (!Reset_n)     r_xl_given <= 1'b0;
        else if (w_start) r_xl_given <= 1'b0;
        else if (w_cross) r_xl_given <= 1'b1;
    end

    // Extra life is applied after any same-cycle death decrement.
    always_comb begin
        w_lives_nx = r_lives;
        if (w_start) w_lives_nx = 2'(START_LIVES);
        else if ((r_state == ST_PLAY) && collision && (r_lives != 2'd0))
            w_lives_nx = r_lives - 2'd1;
        if (w_cross && !r_xl_given && (w_lives_nx != 2'd3))
            w_lives_nx = w_lives_nx + 2'd1;
    end
`else
    always_comb begin
        w_lives_nx = r_lives;
        if (w_start) w_lives_nx = 2'(START_LIVES);
        else if ((r_state == ST_PLAY) && collision && (r_lives != 2'd0))
            w_lives_nx = r_lives - 2'd1;
    end
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_timer     <= 8'd0;
            r_blink     <= 1'b0;
            r_blink_cnt <= 8'd0;
            r_er        <= 1'b0;
            r_lives     <= 2'(START_LIVES);
            r_level     <= 4'd0;
            r_score     <= 14'd0;
        end else begin
            r_er    <= w_er;
            r_lives <= w_lives_nx;
            r_level <= w_level_nx;
            r_score <= w_score_nx;

            if (w_entry)                      r_timer <= w_load;
            else if (w_tick && r_timer != 0)  r_timer <= r_timer - 8'd1;

            if (w_entry || !w_blink_st) begin
                r_blink     <= 1'b0;
                r_blink_cnt <= 8'd0;
            end else if (w_tick) begin
                if (r_blink_cnt == 8'(BLINK_FRAMES - 1)) begin
                    r_blink     <= ~r_blink;
                    r_blink_cnt <= 8'd0;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 8'd1;
                end
            end
        end
    end

    assign game_state   = r_state;
    assign freeze       = (r_state != ST_PLAY);
    assign entity_reset = r_er;
    assign lives        = r_lives;
    assign level        = r_level;
    assign score        = r_score;
    assign blink        = r_blink;

endmodule
